muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the RV32M extension in the execute stage. Accepts one M-type operation from the pipeline, runs a shift-add multiply or a restoring divide over WIDTH cycles, and applies sign correction. It stalls the pipeline while busy and presents a one-cycle `done` with the result. It runs alongside the single-cycle ALU and is selected when the decoded instruction is an M-type operation.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_ctrl.sv | 107 ++++++++++
 tb/tb_muldiv_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_LAT   = MULDIV_WIDTH + 2;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: MSB-first shift-add multiply or restoring divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               bit_in,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   quot_nxt
);
  logic [2*WIDTH-1:0] sh, ext;

  // Divide brings the next dividend bit into the remainder; multiply shifts in zero.
  assign sh  = {acc[2*WIDTH-2:0], is_div & bit_in};
  assign ext = {{WIDTH{1'b0}}, opnd};

  always_comb begin
    acc_nxt  = sh;
    quot_nxt = quot;
    if (is_div) begin
      if (sh >= ext) begin
        acc_nxt  = sh - ext;
        quot_nxt = {quot[WIDTH-2:0], 1'b1};
      end else begin
        quot_nxt = {quot[WIDTH-2:0], 1'b0};
      end
    end else if (bit_in) begin
      acc_nxt = sh + ext;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: magnitude iteration over WIDTH cycles, sign fix-up, one-cycle done.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flushE,
  output logic             stallReq,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state;
  logic [2:0]         f3;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, quot_nxt, fix_val;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [CW-1:0]      cnt;
  logic               neg_res, neg_rem, b_zero;
  logic               a_sgn, b_sgn, neg_a, neg_b, is_div;

  assign a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign neg_a = a_sgn & srcA[WIDTH-1];
  assign neg_b = b_sgn & srcB[WIDTH-1];
  assign is_div = f3[2];

  assign stallReq = (state == IDLE && start) || state == RUN || state == FIX;

  // Counter doubles as the bit index, walking operand bits MSB first.
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .bit_in  (is_div ? a_mag[cnt] : b_mag[cnt]),
    .acc     (acc),
    .quot    (quot),
    .opnd    (is_div ? b_mag : a_mag),
    .acc_nxt (acc_nxt),
    .quot_nxt(quot_nxt)
  );

  always_comb begin
    prod = neg_res ? -acc : acc;
    case (f3)
      F3_MUL:                      fix_val = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
      // Divide by zero keeps the all-ones quotient unnegated.
      F3_DIV, F3_DIVU:             fix_val = (neg_res && !b_zero) ? -quot : quot;
      default:                     fix_val = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      f3      <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      acc     <= '0;
      quot    <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !flushE) begin
          state   <= RUN;
          f3      <= funct3;
          a_mag   <= neg_a ? -srcA : srcA;
          b_mag   <= neg_b ? -srcB : srcB;
          neg_res <= neg_a ^ neg_b;
          neg_rem <= neg_a;
          b_zero  <= (srcB == '0);
          acc     <= '0;
          quot    <= '0;
          cnt     <= CW'(WIDTH - 1);
        end
        RUN: begin
          acc  <= acc_nxt;
          quot <= quot_nxt;
          if (flushE)             state <= IDLE;
          else if (cnt == '0)     state <= FIX;
          else                    cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (flushE) state <= IDLE;
          else begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed RV32M vectors, latency, flush and reset checks.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] srcA, srcB;
  logic        flushE;
  logic        stallReq, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .flushE(flushE),
    .stallReq(stallReq), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #1;
    if (done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (result !== e) begin
          fails++;
          $display("FAIL result: got %h expected %h", result, e);
        end
        last_res = e;
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit inject);
    int cyc, n_stall;
    @(negedge clk);
    funct3 = f; srcA = a; srcB = b; start = 1'b1;
    sb.push_back(exp);
    #1 n_stall = stallReq ? 1 : 0;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (inject && cyc == 5) begin
        start = 1'b1; funct3 = 3'b000; srcA = 32'hDEAD_BEEF; srcB = 32'h1234_5678;
      end
      #1;
      if (stallReq) n_stall++;
    end while (!done && cyc < 100);
    start = 1'b0;
    check({name, "_done_cycle"}, cyc, 34);
    check({name, "_stall_cycles"}, n_stall, 34);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = '0; srcA = '0; srcB = '0; flushE = 1'b0;
    last_res = '0;
    #1;
    check("reset_stall", {31'b0, stallReq}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("mul_neg",   3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh",      3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhu",     3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0);
    run_op("mul_wrap",  3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);
    run_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,        0);
    run_op("remu",      3'b111, 32'd100,      32'd7,        32'd2,         0);
    run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0);
    run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
    run_op("div_zero",  3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
    run_op("remu_zero", 3'b111, 32'h1234,     32'd0,        32'h1234,      0);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("divu_max",  3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1);

    // Flush 10 cycles into RUN: no done, result held.
    @(negedge clk);
    funct3 = 3'b101; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flushE = 1'b1;
    @(negedge clk); flushE = 1'b0;
    #1;
    check("flush_stall", {31'b0, stallReq}, 0);
    check("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    check("flush_result_held", result, last_res);
    run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, 0);

    // Flush with start in IDLE: start ignored.
    @(negedge clk);
    funct3 = 3'b000; srcA = 32'd9; srcB = 32'd9; start = 1'b1; flushE = 1'b1;
    @(negedge clk); start = 1'b0; flushE = 1'b0;
    #1 check("flush_start_ignored", {31'b0, stallReq}, 0);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    funct3 = 3'b000; srcA = 32'd11; srcB = 32'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_stall", {31'b0, stallReq}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_result", result, 0);
    last_res = '0;
    @(negedge clk); reset = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_idle_stall", {31'b0, stallReq}, 0);
    run_op("after_reset", 3'b000, 32'd11, 32'd13, 32'd143, 0);

    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
